// File: rtl/mem_sched_pkg.sv
// rtl/mem_sched_pkg.sv - shared types and helpers for the memory request scheduler
package mem_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        READ_WAIT,
        WRITE_WAIT,
        READ_RELAY,
        WRITE_RELAY
    } chan_state_e;

    typedef enum logic {
        OP_READ,
        OP_WRITE
    } op_e;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// rtl/rr_priority_picker.sv - picks the first set request scanning upward from a pointer
module rr_priority_picker #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] grant,
    output logic [W-1:0] index,
    output logic         found
);

    always_comb begin
        logic [W-1:0] sel;
        grant = '0;
        index = '0;
        found = 1'b0;
        sel   = '0;
        for (int i = 0; i < N; i++) begin
            sel = W'((int'(ptr) + i) % N);
            if (!found && req[sel]) begin
                found      = 1'b1;
                grant[sel] = 1'b1;
                index      = sel;
            end
        end
    end

endmodule

// File: rtl/mem_request_scheduler.sv
// rtl/mem_request_scheduler.sv - shares memory channels among consumers with held round-robin handshakes
module mem_request_scheduler
    import mem_sched_pkg::*;
#(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 8,
    parameter int NUM_CONSUMERS = 4,
    parameter int NUM_CHANNELS  = 2,
    parameter int WRITE_ENABLE  = 1
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic [NUM_CONSUMERS-1:0]                 consumer_read_valid,
    input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]  consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]                 consumer_read_ready,
    output logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]  consumer_read_data,
    input  logic [NUM_CONSUMERS-1:0]                 consumer_write_valid,
    input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]  consumer_write_address,
    input  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]  consumer_write_data,
    output logic [NUM_CONSUMERS-1:0]                 consumer_write_ready,
    output logic [NUM_CHANNELS-1:0]                  mem_read_valid,
    output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]   mem_read_address,
    input  logic [NUM_CHANNELS-1:0]                  mem_read_ready,
    input  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]   mem_read_data,
    output logic [NUM_CHANNELS-1:0]                  mem_write_valid,
    output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]   mem_write_address,
    output logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]   mem_write_data,
    input  logic [NUM_CHANNELS-1:0]                  mem_write_ready,
    output logic                                     idle
);

    localparam int   IDW = id_width(NUM_CONSUMERS);
    localparam logic WE  = (WRITE_ENABLE != 0);

    logic [IDW-1:0]           rr_ptr;
    logic [IDW-1:0]           next_ptr;
    chan_state_e              st       [NUM_CHANNELS];
    logic [IDW-1:0]           cid      [NUM_CHANNELS];
    logic [NUM_CONSUMERS-1:0] mask     [NUM_CHANNELS+1];
    logic [NUM_CONSUMERS-1:0] grant    [NUM_CHANNELS];
    logic [IDW-1:0]           gidx     [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0]  found;
    logic [NUM_CHANNELS-1:0]  chan_to_idle;
    logic [NUM_CONSUMERS-1:0] claimed;

    // Any non-IDLE channel (including one releasing this cycle) keeps its consumer off-limits.
    always_comb begin
        claimed = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (st[c] != IDLE) claimed[cid[c]] = 1'b1;
        end
    end

    assign mask[0] = (consumer_read_valid | (consumer_write_valid & {NUM_CONSUMERS{WE}})) & ~claimed;

    // The last granting channel holds the furthest id in scan order.
    always_comb begin
        next_ptr = rr_ptr;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (found[c]) begin
                next_ptr = (int'(gidx[c]) == NUM_CONSUMERS - 1) ? '0 : gidx[c] + 1'b1;
            end
        end
    end

    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_chan
        chan_state_e              state;
        logic [IDW-1:0]           id;
        logic [ADDR_BITS-1:0]     addr;
        logic [DATA_BITS-1:0]     wdata;
        logic                     rvalid;
        logic                     wvalid;
        logic                     cur_valid;
        logic [NUM_CONSUMERS-1:0] req;
        op_e                      op;

        assign req = (state == IDLE) ? mask[c] : '0;

        rr_priority_picker #(.N(NUM_CONSUMERS), .W(IDW)) u_pick (
            .req   (req),
            .ptr   (rr_ptr),
            .grant (grant[c]),
            .index (gidx[c]),
            .found (found[c])
        );

        assign mask[c+1] = mask[c] & ~grant[c];
        assign op        = consumer_read_valid[gidx[c]] ? OP_READ : OP_WRITE;
        assign cur_valid = (state == READ_RELAY) ? consumer_read_valid[id] : consumer_write_valid[id];
        assign chan_to_idle[c] = ((state == IDLE) && !found[c]) ||
                                 (((state == READ_RELAY) || (state == WRITE_RELAY)) && !cur_valid);

        always_ff @(posedge clk) begin
            if (reset) begin
                state  <= IDLE;
                id     <= '0;
                addr   <= '0;
                wdata  <= '0;
                rvalid <= 1'b0;
                wvalid <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (found[c]) begin
                        id <= gidx[c];
                        if (op == OP_READ) begin
                            state  <= READ_WAIT;
                            rvalid <= 1'b1;
                            addr   <= consumer_read_address[gidx[c]];
                        end else begin
                            state  <= WRITE_WAIT;
                            wvalid <= 1'b1;
                            addr   <= consumer_write_address[gidx[c]];
                            wdata  <= consumer_write_data[gidx[c]];
                        end
                    end
                    READ_WAIT: if (mem_read_ready[c]) begin
                        rvalid <= 1'b0;
                        state  <= READ_RELAY;
                    end
                    WRITE_WAIT: if (mem_write_ready[c]) begin
                        wvalid <= 1'b0;
                        state  <= WRITE_RELAY;
                    end
                    READ_RELAY, WRITE_RELAY: if (!cur_valid) state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end

        assign st[c]                = state;
        assign cid[c]               = id;
        assign mem_read_valid[c]    = rvalid;
        assign mem_read_address[c]  = addr;
        assign mem_write_valid[c]   = wvalid & WE;
        assign mem_write_address[c] = WE ? addr : '0;
        assign mem_write_data[c]    = WE ? wdata : '0;
    end

    // Consumer-facing handshake registers are owned here so each bit has one driver.
    always_ff @(posedge clk) begin
        if (reset) begin
            consumer_read_ready  <= '0;
            consumer_read_data   <= '0;
            consumer_write_ready <= '0;
            rr_ptr               <= '0;
            idle                 <= 1'b1;
        end else begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                if (st[c] == READ_WAIT && mem_read_ready[c]) begin
                    consumer_read_ready[cid[c]] <= 1'b1;
                    consumer_read_data[cid[c]]  <= mem_read_data[c];
                end
                if (st[c] == WRITE_WAIT && mem_write_ready[c] && WE) begin
                    consumer_write_ready[cid[c]] <= 1'b1;
                end
                if (st[c] == READ_RELAY && !consumer_read_valid[cid[c]]) begin
                    consumer_read_ready[cid[c]] <= 1'b0;
                end
                if (st[c] == WRITE_RELAY && !consumer_write_valid[cid[c]]) begin
                    consumer_write_ready[cid[c]] <= 1'b0;
                end
            end
            rr_ptr <= next_ptr;
            idle   <= &chan_to_idle;
        end
    end

endmodule

// File: tb/tb_mem_request_scheduler.sv
// tb/tb_mem_request_scheduler.sv - self-checking bench for mem_request_scheduler
module tb_mem_request_scheduler;

    localparam int AB  = 8;
    localparam int DB  = 8;
    localparam int NC  = 4;
    localparam int NCH = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic [NC-1:0]          rv, wv, rrdy, wrdy;
    logic [NC-1:0][AB-1:0]  raddr, waddr;
    logic [NC-1:0][DB-1:0]  wdat, rdat;
    logic [NCH-1:0]         mrv, mrr, mwv, mwr;
    logic [NCH-1:0][AB-1:0] mra, mwa;
    logic [NCH-1:0][DB-1:0] mrd, mwd;
    logic                   idle;

    logic [NC-1:0]          rv_z, wv_z, rrdy_z, wrdy_z;
    logic [NC-1:0][AB-1:0]  raddr_z, waddr_z;
    logic [NC-1:0][DB-1:0]  wdat_z, rdat_z;
    logic [NCH-1:0]         mrv_z, mrr_z, mwv_z, mwr_z;
    logic [NCH-1:0][AB-1:0] mra_z, mwa_z;
    logic [NCH-1:0][DB-1:0] mrd_z, mwd_z;
    logic                   idle_z;

    mem_request_scheduler #(.ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CONSUMERS(NC),
                            .NUM_CHANNELS(NCH), .WRITE_ENABLE(1)) dut (
        .clk(clk), .reset(reset),
        .consumer_read_valid(rv), .consumer_read_address(raddr),
        .consumer_read_ready(rrdy), .consumer_read_data(rdat),
        .consumer_write_valid(wv), .consumer_write_address(waddr),
        .consumer_write_data(wdat), .consumer_write_ready(wrdy),
        .mem_read_valid(mrv), .mem_read_address(mra),
        .mem_read_ready(mrr), .mem_read_data(mrd),
        .mem_write_valid(mwv), .mem_write_address(mwa), .mem_write_data(mwd),
        .mem_write_ready(mwr), .idle(idle)
    );

    mem_request_scheduler #(.ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CONSUMERS(NC),
                            .NUM_CHANNELS(NCH), .WRITE_ENABLE(0)) dut_we0 (
        .clk(clk), .reset(reset),
        .consumer_read_valid(rv_z), .consumer_read_address(raddr_z),
        .consumer_read_ready(rrdy_z), .consumer_read_data(rdat_z),
        .consumer_write_valid(wv_z), .consumer_write_address(waddr_z),
        .consumer_write_data(wdat_z), .consumer_write_ready(wrdy_z),
        .mem_read_valid(mrv_z), .mem_read_address(mra_z),
        .mem_read_ready(mrr_z), .mem_read_data(mrd_z),
        .mem_write_valid(mwv_z), .mem_write_address(mwa_z), .mem_write_data(mwd_z),
        .mem_write_ready(mwr_z), .idle(idle_z)
    );

    // Transaction-level view: each channel either holds nothing or one consumer's op,
    // which is pending at memory until done, then relaying until the consumer lets go.
    typedef struct {
        bit            act;
        bit            wr;
        bit            done;
        int            who;
        logic [AB-1:0] a;
        logic [DB-1:0] d;
    } txn_t;

    txn_t          ch [NCH];
    int            m_rr;
    logic [DB-1:0] m_rdata [NC];

    int  n_pass, n_total;
    bit  auto_mem, auto_cons, mem_hold;
    int  rcnt [NCH];
    int  wcnt [NCH];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        else n_pass++;
    endtask

    task automatic model_update();
        txn_t nx [NCH];
        int   q[$];
        int   last;
        bit   owned;
        if (reset) begin
            for (int c = 0; c < NCH; c++) ch[c] = '{0, 0, 0, 0, '0, '0};
            for (int i = 0; i < NC; i++) m_rdata[i] = '0;
            m_rr = 0;
            return;
        end
        for (int c = 0; c < NCH; c++) begin
            nx[c] = ch[c];
            if (ch[c].act && !ch[c].done) begin
                if (!ch[c].wr && mrr[c]) begin
                    nx[c].done = 1;
                    m_rdata[ch[c].who] = mrd[c];
                end
                if (ch[c].wr && mwr[c]) nx[c].done = 1;
            end else if (ch[c].act) begin
                if (!(ch[c].wr ? wv[ch[c].who] : rv[ch[c].who])) nx[c].act = 0;
            end
        end
        for (int k = 0; k < NC; k++) begin
            int i;
            i = (m_rr + k) % NC;
            owned = 0;
            for (int c = 0; c < NCH; c++) if (ch[c].act && ch[c].who == i) owned = 1;
            if ((rv[i] || wv[i]) && !owned) q.push_back(i);
        end
        last = -1;
        for (int c = 0; c < NCH; c++) begin
            if (!ch[c].act && q.size() > 0) begin
                int i;
                i = q.pop_front();
                nx[c].act  = 1;
                nx[c].done = 0;
                nx[c].who  = i;
                nx[c].wr   = !rv[i];
                nx[c].a    = rv[i] ? raddr[i] : waddr[i];
                nx[c].d    = wdat[i];
                last = i;
            end
        end
        if (last >= 0) m_rr = (last + 1) % NC;
        for (int c = 0; c < NCH; c++) ch[c] = nx[c];
    endtask

    task automatic compare_all();
        logic [NCH-1:0] e_mrv, e_mwv;
        logic [NC-1:0]  e_rr, e_wr;
        logic           e_idle;
        e_mrv = '0; e_mwv = '0; e_rr = '0; e_wr = '0; e_idle = 1'b1;
        for (int c = 0; c < NCH; c++) begin
            if (ch[c].act) begin
                e_idle = 1'b0;
                if (!ch[c].done) begin
                    if (ch[c].wr) e_mwv[c] = 1'b1; else e_mrv[c] = 1'b1;
                end else begin
                    if (ch[c].wr) e_wr[ch[c].who] = 1'b1; else e_rr[ch[c].who] = 1'b1;
                end
            end
        end
        chk("mem_read_valid", 32'(mrv), 32'(e_mrv));
        chk("mem_write_valid", 32'(mwv), 32'(e_mwv));
        chk("consumer_read_ready", 32'(rrdy), 32'(e_rr));
        chk("consumer_write_ready", 32'(wrdy), 32'(e_wr));
        chk("idle", 32'(idle), 32'(e_idle));
        for (int c = 0; c < NCH; c++) begin
            if (e_mrv[c]) chk("mem_read_address", 32'(mra[c]), 32'(ch[c].a));
            if (e_mwv[c]) begin
                chk("mem_write_address", 32'(mwa[c]), 32'(ch[c].a));
                chk("mem_write_data", 32'(mwd[c]), 32'(ch[c].d));
            end
        end
        for (int i = 0; i < NC; i++) chk("consumer_read_data", 32'(rdat[i]), 32'(m_rdata[i]));
        chk("we0_mem_write_valid", 32'(mwv_z), 32'd0);
        chk("we0_mem_read_valid", 32'(mrv_z), 32'd0);
        chk("we0_consumer_write_ready", 32'(wrdy_z), 32'd0);
        chk("we0_idle", 32'(idle_z), 32'd1);
    endtask

    task automatic react();
        if (auto_cons) begin
            for (int i = 0; i < NC; i++) begin
                if (rrdy[i]) rv[i] = 1'b0;
                if (wrdy[i]) wv[i] = 1'b0;
            end
        end
        for (int c = 0; c < NCH; c++) begin
            if (mem_hold) begin
                mrr[c] = 1'b1;
            end else if (auto_mem) begin
                if (mrr[c]) mrr[c] = 1'b0;
                else if (mrv[c]) begin
                    rcnt[c]++;
                    if (rcnt[c] >= 2) begin
                        mrr[c] = 1'b1; mrd[c] = mra[c] ^ 8'h99; rcnt[c] = 0;
                    end
                end else rcnt[c] = 0;
                if (mwr[c]) mwr[c] = 1'b0;
                else if (mwv[c]) begin
                    wcnt[c]++;
                    if (wcnt[c] >= 2) begin mwr[c] = 1'b1; wcnt[c] = 0; end
                end else wcnt[c] = 0;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
        compare_all();
        react();
    endtask

    task automatic wait_idle(input string nm);
        for (int k = 0; k < 60 && !(idle === 1'b1 && rv == '0 && wv == '0); k++) step();
        chk(nm, 32'(idle), 32'd1);
    endtask

    initial begin
        n_pass = 0; n_total = 0;
        reset = 1'b1;
        rv = '0; wv = '0; raddr = '0; waddr = '0; wdat = '0;
        mrr = '0; mwr = '0; mrd = '0;
        rv_z = '0; wv_z = '1; raddr_z = '0; waddr_z = '{8'h13, 8'h12, 8'h11, 8'h10};
        wdat_z = '1; mrr_z = '0; mwr_z = '1; mrd_z = '0;
        auto_mem = 1; auto_cons = 1; mem_hold = 0;
        for (int c = 0; c < NCH; c++) begin rcnt[c] = 0; wcnt[c] = 0; end
        m_rr = 0;
        step(); step();
        chk("reset_idle", 32'(idle), 32'd1);
        chk("reset_mem_read_valid", 32'(mrv), 32'd0);
        chk("reset_read_ready", 32'(rrdy), 32'd0);
        reset = 1'b0;

        // Single read, consumer 1, addr 0x3C -> 0xA5
        raddr[1] = 8'h3C; rv[1] = 1'b1;
        step();
        chk("t1_mem_valid_latency", 32'(mrv), 32'h1);
        chk("t1_mem_addr", 32'(mra[0]), 32'h3C);
        for (int k = 0; k < 20 && rrdy[1] !== 1'b1; k++) step();
        chk("t1_ready", 32'(rrdy), 32'h2);
        chk("t1_data", 32'(rdat[1]), 32'hA5);
        step();
        chk("t1_ready_drop", 32'(rrdy), 32'h0);
        chk("t1_idle", 32'(idle), 32'd1);

        // Contention from reset: all four read at once
        reset = 1'b1; step(); reset = 1'b0;
        for (int i = 0; i < NC; i++) raddr[i] = 8'(8'h40 + i);
        rv = 4'hF;
        step();
        chk("t2_round1_valid", 32'(mrv), 32'h3);
        chk("t2_round1_ch0", 32'(mra[0]), 32'h40);
        chk("t2_round1_ch1", 32'(mra[1]), 32'h41);
        chk("t2_model_rr_2", 32'(m_rr), 32'd2);
        for (int k = 0; k < 30 && !(mrv == 2'b11 && mra[0] == 8'h42); k++) step();
        chk("t2_round2_ch0", 32'(mra[0]), 32'h42);
        chk("t2_round2_ch1", 32'(mra[1]), 32'h43);
        chk("t2_model_rr_0", 32'(m_rr), 32'd0);
        wait_idle("t2_idle");
        chk("t2_data0", 32'(rdat[0]), 32'hD9);
        chk("t2_data3", 32'(rdat[3]), 32'hDA);

        // Read and write together on consumer 2: read first
        raddr[2] = 8'h20; waddr[2] = 8'h10; wdat[2] = 8'h7E;
        rv[2] = 1'b1; wv[2] = 1'b1;
        step();
        chk("t3_read_first", 32'(mrv), 32'h1);
        chk("t3_no_write_yet", 32'(mwv), 32'h0);
        for (int k = 0; k < 40 && mwv == '0; k++) step();
        chk("t3_write_valid", 32'(mwv), 32'h1);
        chk("t3_write_addr", 32'(mwa[0]), 32'h10);
        chk("t3_write_data", 32'(mwd[0]), 32'h7E);
        chk("t3_read_data_before", 32'(rdat[2]), 32'hB9);
        wait_idle("t3_idle");

        // Reset during READ_WAIT, then a late memory ready
        auto_mem = 0; mrr = '0; mwr = '0;
        raddr[0] = 8'h55; rv[0] = 1'b1;
        step();
        chk("t5_granted", 32'(mrv), 32'h1);
        step();
        reset = 1'b1; rv = '0;
        step();
        chk("t5_valid_cleared", 32'(mrv), 32'h0);
        chk("t5_idle", 32'(idle), 32'd1);
        reset = 1'b0; mrr = 2'b01; mrd[0] = 8'hEE;
        step();
        mrr = '0;
        step();
        chk("t5_no_ready", 32'(rrdy), 32'h0);
        chk("t5_data_zero", 32'(rdat[0]), 32'h0);
        auto_mem = 1;

        // mem_read_ready held high while idle
        mem_hold = 1; mrd[0] = 8'h12; mrd[1] = 8'h12;
        step(); step(); step();
        chk("t6_quiet_valid", 32'(mrv), 32'h0);
        chk("t6_quiet_ready", 32'(rrdy), 32'h0);
        raddr[3] = 8'h77; rv[3] = 1'b1;
        step();
        chk("t6_grant", 32'(mrv), 32'h1);
        step();
        chk("t6_complete", 32'(rrdy), 32'h8);
        chk("t6_data", 32'(rdat[3]), 32'h12);
        chk("t6_valid_low", 32'(mrv), 32'h0);
        mem_hold = 0;
        wait_idle("t6_idle");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mem_request_scheduler.md
Name: mem_request_scheduler

Overview:
Transaction-level scheduler that shares NUM_CHANNELS memory channels among NUM_CONSUMERS requesters (LSUs or fetchers).
Each channel runs its own FSM and owns one consumer for the full handshake: grant, memory wait, data return and consumer release.
Grants are round-robin and no consumer is ever held by two channels.
It sits between the cores and the program/data memory ports and replaces per-cycle arbitration with a held, ordered handshake.

Parameters:
ADDR_BITS, 8, address width
DATA_BITS, 8, data width (16 for program memory)
NUM_CONSUMERS, 4, requester count (>=2)
NUM_CHANNELS, 2, memory channel count (>=1, <=NUM_CONSUMERS)
WRITE_ENABLE, 1, 1 = data memory (reads and writes), 0 = program memory (read only)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
consumer_read_valid  in  NUM_CONSUMERS  read request, held until ready
consumer_read_address  in  ADDR_BITS x NUM_CONSUMERS  read address
consumer_read_ready  out  NUM_CONSUMERS  read done, data valid
consumer_read_data  out  DATA_BITS x NUM_CONSUMERS  returned data
consumer_write_valid  in  NUM_CONSUMERS  write request, held until ready
consumer_write_address  in  ADDR_BITS x NUM_CONSUMERS  write address
consumer_write_data  in  DATA_BITS x NUM_CONSUMERS  write data
consumer_write_ready  out  NUM_CONSUMERS  write done
mem_read_valid  out  NUM_CHANNELS  channel read request
mem_read_address  out  ADDR_BITS x NUM_CHANNELS  channel read address
mem_read_ready  in  NUM_CHANNELS  memory read done, data valid
mem_read_data  in  DATA_BITS x NUM_CHANNELS  memory data
mem_write_valid  out  NUM_CHANNELS  channel write request
mem_write_address  out  ADDR_BITS x NUM_CHANNELS  channel write address
mem_write_data  out  DATA_BITS x NUM_CHANNELS  channel write data
mem_write_ready  in  NUM_CHANNELS  memory write done
idle  out  1  all channels are in IDLE

Behaviour:
- One clock, clk. Reset is synchronous and active-high.
- Reset:
  - all outputs 0, except idle = 1;
  - every FSM goes to IDLE, rr_ptr = 0, all claims cleared;
  - reset mid-transaction aborts it: mem_*_valid is 0 after the edge, and late mem ready pulses are ignored.
- All outputs are registered.
- Channel FSM states: IDLE, READ_WAIT, WRITE_WAIT, READ_RELAY, WRITE_RELAY.
- Eligible consumer:
  - (read_valid | (WRITE_ENABLE & write_valid)), and
  - not claimed by any channel, and
  - not completing its release this cycle.
- Arbitration, each cycle:
  - IDLE channels are served in ascending index order.
  - Each picks the first eligible consumer scanning rr_ptr, rr_ptr+1, ... mod NUM_CONSUMERS.
  - A consumer picked by a lower channel is masked for higher channels.
  - rr_ptr <= (highest-scan-order granted id + 1) mod NUM_CONSUMERS; unchanged if no grant.
- Grant:
  - Read has priority when both read and write valid are set; the write is served in a later transaction.
  - Latch the consumer id and address (plus data for writes).
  - Next cycle: mem_read_valid or mem_write_valid = 1, FSM enters READ_WAIT or WRITE_WAIT.
- READ_WAIT:
  - hold valid and address stable;
  - on mem_read_ready: mem_read_valid <= 0, consumer_read_data[id] <= mem_read_data, consumer_read_ready[id] <= 1, go to READ_RELAY.
- WRITE_WAIT: same as READ_WAIT with write signals; no data is returned.
- Memory ready in IDLE or RELAY: ignored.
- RELAY:
  - consumer ready held at 1 until the consumer's valid for that op is sampled 0;
  - then ready <= 0, claim released, FSM to IDLE;
  - the channel can re-grant on the cycle after it reaches IDLE.
- Latency:
  - consumer valid sampled at edge N gives mem valid at N+1 (best case);
  - mem ready at edge K gives consumer ready at K+1;
  - consumer valid dropped at edge R gives ready 0 at R+1.
- consumer_read_data[i] holds its value until that consumer's next read completes.
- Consumer valid dropped during WAIT is a protocol violation. The transaction still completes; RELAY then exits on the next edge.
- WRITE_ENABLE = 0: mem_write_* and consumer_write_ready are held 0; write_valid is ignored.
- idle = 1 iff every FSM is in IDLE.

Decomposition:
- Package mem_sched_pkg holds:
  - the chan_state_e enum (5 states);
  - the op type (READ/WRITE);
  - a helper function for consumer-id width: max(1, $clog2(NUM_CONSUMERS)).
- Sub-module rr_priority_picker:
  - combinational;
  - inputs: request mask, pointer;
  - outputs: one-hot grant, index, found.
- The top instantiates one rr_priority_picker per channel, chained through masks, plus a generate loop of per-channel FSM registers.

Test Plan:
- Single read, memory 2-cycle latency: consumer 1 reads addr 0x3C, memory returns 0xA5 → mem_read_valid[0] rises 1 cycle after request; consumer_read_ready[1] = 1 with data 0xA5; ready drops 1 cycle after valid drops; idle returns to 1.
- Contention, NUM_CHANNELS = 2, all 4 consumers reading at once from reset → grants {0,1} first, then {2,3}; rr_ptr progression 0→2→0; no consumer is granted twice and none waits more than 2 rounds.
- Simultaneous read and write on consumer 2, WRITE_ENABLE = 1 → read serviced first; write to addr 0x10 with data 0x7E issued only after the read's RELAY exits.
- WRITE_ENABLE = 0 with write_valid on every consumer → mem_write_valid stays 0, consumer_write_ready stays 0, idle stays 1.
- Reset asserted during READ_WAIT, then mem_read_ready pulses → all outputs 0 after the edge; the ready pulse produces no consumer_read_ready.
- mem_read_ready held 1 while IDLE with no requests → no valid or ready activity; after a request arrives, the grant takes 1 cycle and completion the following cycle.
